// File: rtl/sonar_pkg.sv
// Shared definitions for the multi-channel ultrasonic ranging controller.
package sonar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_CLK_HZ     = 50_000_000;
  localparam int unsigned DEF_CYC_PER_MM = 295;

  // Bits needed to hold an index 0..n-1 (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sonar_ranging_array_echo_sync.sv
// Parametrised N-bit two-flop synchroniser for the raw echo lines.
module echo_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two register stages; both edges see the same delay so width is preserved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sonar_ranging_array.sv
// Round-robin HC-SR04 style ranging controller: trigger, echo timing, result banks.
module sonar_ranging_array
  import sonar_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DIST_W      = 12,
  parameter int unsigned SLOT_CYC    = 1250000,
  parameter int unsigned TRIG_CYC    = 500,
  parameter int unsigned CYC_PER_MM  = DEF_CYC_PER_MM,
  parameter int unsigned MAX_MM      = 4000,
  parameter int unsigned RISE_TO_CYC = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [N_CH-1:0]        echo,
  output logic [N_CH-1:0]        trig,
  output logic [N_CH*DIST_W-1:0] dist_mm,
  output logic [N_CH-1:0]        valid,
  output logic [N_CH-1:0]        no_echo,
  output logic [N_CH-1:0]        over_range,
  output logic                   upd,
  output logic [2:0]             upd_ch
);

  localparam int unsigned CH_W = idx_w(N_CH);
  localparam int unsigned SC_W = idx_w(SLOT_CYC);
  localparam int unsigned WC_W = idx_w(RISE_TO_CYC);
  localparam int unsigned PS_W = idx_w(CYC_PER_MM);

  state_t            state, state_d;
  logic [CH_W-1:0]   ch, ch_nx, ch_d;
  logic [SC_W-1:0]   sc;
  logic [WC_W-1:0]   wc;
  logic [PS_W-1:0]   ps;
  logic [DIST_W-1:0] mm;
  logic [N_CH-1:0]   echo_s, echo_p;
  logic              echo_cur, echo_rise, slot_end;
  logic              wr_c, wr_dist_c, meas_start_c;
  logic              res_valid_c, res_ne_c, res_over_c;
  logic [DIST_W-1:0] res_dist_c;

  echo_sync #(.W(N_CH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (echo),
    .q     (echo_s)
  );

  assign echo_cur  = echo_s[ch];
  assign echo_rise = echo_s[ch] & ~echo_p[ch];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Next state, slot-end handling and result-write decode.
  always_comb begin
    state_d      = state;
    wr_c         = 1'b0;
    wr_dist_c    = 1'b0;
    meas_start_c = 1'b0;
    res_dist_c   = mm;
    res_valid_c  = 1'b0;
    res_ne_c     = 1'b0;
    res_over_c   = 1'b0;
    slot_end     = (state != ST_IDLE) && (sc == SC_W'(SLOT_CYC - 1));
    ch_nx        = (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
    ch_d         = slot_end ? ch_nx : ch;

    case (state)
      ST_IDLE:  if (enable) state_d = ST_TRIG;
      ST_TRIG:  if (sc == SC_W'(TRIG_CYC - 1)) state_d = ST_WAIT_RISE;
      ST_WAIT_RISE: begin
        if (echo_rise) begin
          meas_start_c = 1'b1;
          state_d      = ST_MEASURE;
        end else if (wc == WC_W'(RISE_TO_CYC - 1)) begin
          wr_c     = 1'b1;
          res_ne_c = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_MEASURE: begin
        if (!echo_cur) begin
          wr_c        = 1'b1;
          wr_dist_c   = 1'b1;
          res_valid_c = (mm < DIST_W'(MAX_MM));
          res_over_c  = (mm == DIST_W'(MAX_MM));
          state_d     = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    // Slot end wins over everything; an unfinished echo is reported as over-range.
    if (slot_end) begin
      if (state == ST_MEASURE) begin
        wr_c        = 1'b1;
        wr_dist_c   = 1'b1;
        res_dist_c  = DIST_W'(MAX_MM);
        res_valid_c = 1'b0;
        res_ne_c    = 1'b0;
        res_over_c  = 1'b1;
      end
      state_d = enable ? ST_TRIG : ST_IDLE;
    end
  end

  // Slot, channel, wait and distance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc     <= '0;
      ch     <= '0;
      wc     <= '0;
      ps     <= '0;
      mm     <= '0;
      echo_p <= '0;
    end else begin
      echo_p <= echo_s;
      if (state != ST_IDLE) sc <= slot_end ? '0 : sc + 1'b1;
      if (slot_end) ch <= ch_nx;
      if (state == ST_WAIT_RISE) wc <= wc + 1'b1;
      else                       wc <= '0;
      if (meas_start_c) begin
        // The cycle that reveals the rise is itself an echo-high cycle.
        if (CYC_PER_MM == 1) begin
          ps <= '0;
          mm <= DIST_W'(1);
        end else begin
          ps <= PS_W'(1);
          mm <= '0;
        end
      end else if (state == ST_MEASURE && echo_cur) begin
        if (ps == PS_W'(CYC_PER_MM - 1)) begin
          ps <= '0;
          if (mm != DIST_W'(MAX_MM)) mm <= mm + 1'b1;
        end else begin
          ps <= ps + 1'b1;
        end
      end
    end
  end

  // Trigger lines and per-channel result banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig       <= '0;
      dist_mm    <= '0;
      valid      <= '0;
      no_echo    <= '0;
      over_range <= '0;
      upd        <= 1'b0;
      upd_ch     <= '0;
    end else begin
      upd <= wr_c;
      if (wr_c) upd_ch <= 3'(ch);
      for (int k = 0; k < int'(N_CH); k++) begin
        trig[k] <= (state_d == ST_TRIG) && (ch_d == CH_W'(k));
        if (wr_c && ch == CH_W'(k)) begin
          valid[k]      <= res_valid_c;
          no_echo[k]    <= res_ne_c;
          over_range[k] <= res_over_c;
          if (wr_dist_c) dist_mm[k*DIST_W +: DIST_W] <= res_dist_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_sonar_ranging_array.sv
// Self-checking bench for sonar_ranging_array with scaled-down timing.
module tb_sonar_ranging_array;

  localparam int N_CH        = 4;
  localparam int DIST_W      = 12;
  localparam int SLOT_CYC    = 2500;
  localparam int TRIG_CYC    = 10;
  localparam int CYC_PER_MM  = 5;
  localparam int MAX_MM      = 400;
  localparam int RISE_TO_CYC = 800;

  localparam int K_PULSE = 0;
  localparam int K_NONE  = 1;
  localparam int K_HOLD  = 2;

  typedef struct {
    int dly;
    int h;
    int kind;
    int e_dist;
    bit e_valid;
    bit e_ne;
    bit e_over;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   enable = 1'b0;
  logic [N_CH-1:0]        echo = '0;
  logic [N_CH-1:0]        trig;
  logic [N_CH*DIST_W-1:0] dist_mm;
  logic [N_CH-1:0]        valid, no_echo, over_range;
  logic                   upd;
  logic [2:0]             upd_ch;

  sonar_ranging_array #(
    .N_CH(N_CH), .DIST_W(DIST_W), .SLOT_CYC(SLOT_CYC), .TRIG_CYC(TRIG_CYC),
    .CYC_PER_MM(CYC_PER_MM), .MAX_MM(MAX_MM), .RISE_TO_CYC(RISE_TO_CYC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
    .dist_mm(dist_mm), .valid(valid), .no_echo(no_echo), .over_range(over_range),
    .upd(upd), .upd_ch(upd_ch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int overlap = 0;
  int exp_ch = 0;

  logic [N_CH*DIST_W-1:0] m_dist = '0;
  logic [N_CH-1:0]        m_valid = '0, m_ne = '0, m_over = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Trigger exclusivity observed every cycle.
  always @(negedge clk) if (!reset && $countones(trig) > 1) overlap++;

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: result of one slot from the pulse description.
  function automatic void model(input int kind, input int h, input int prev,
                                output int d, output bit v, output bit ne, output bit o);
    d = prev; v = 1'b0; ne = 1'b0; o = 1'b0;
    if (kind == K_NONE) begin
      ne = 1'b1;
    end else if (kind == K_HOLD) begin
      d = MAX_MM; o = 1'b1;
    end else begin
      d = h / CYC_PER_MM;
      if (d >= MAX_MM) begin d = MAX_MM; o = 1'b1; end
      else v = 1'b1;
    end
  endfunction

  function automatic int prev_dist(input int c);
    return int'(m_dist[c*DIST_W +: DIST_W]);
  endfunction

  task automatic wait_upd(input int bound, output int n);
    n = 0;
    while (!upd && n < bound) begin tick(); n++; end
  endtask

  // Runs one measurement slot on the expected channel and checks the result.
  task automatic run_slot(input int dly, input int h, input int kind, input bit drop,
                          input bit noise, input int e_dist, input bit e_v,
                          input bit e_ne, input bit e_o);
    int n;
    int t_rise;
    int other;
    logic [N_CH-1:0] oh;
    other = (exp_ch + 1) % N_CH;
    oh = '0;
    oh[exp_ch] = 1'b1;
    n = 0;
    while (trig == '0 && n < 2 * SLOT_CYC) begin tick(); n++; end
    t_rise = cyc;
    check("trig_sel", 64'(trig), 64'(oh));
    n = 0;
    while (trig[exp_ch] && n < TRIG_CYC + 5) begin tick(); n++; end
    check("trig_width", 64'(n), 64'(TRIG_CYC));
    if (drop) enable = 1'b0;
    if (noise) echo[other] = 1'b1;
    if (kind == K_NONE) begin
      wait_upd(RISE_TO_CYC + 20, n);
    end else begin
      repeat (dly) tick();
      echo[exp_ch] = 1'b1;
      if (kind == K_PULSE) begin
        repeat (h) tick();
        echo[exp_ch] = 1'b0;
        wait_upd(10, n);
        check("upd_latency", 64'(n), 64'd3);
      end else begin
        wait_upd(SLOT_CYC, n);
        check("slot_end_upd", 64'(cyc - t_rise), 64'(SLOT_CYC));
      end
    end
    echo = '0;
    m_dist[exp_ch*DIST_W +: DIST_W] = DIST_W'(e_dist);
    m_valid[exp_ch] = e_v;
    m_ne[exp_ch]    = e_ne;
    m_over[exp_ch]  = e_o;
    check("upd", 64'(upd), 64'd1);
    check("upd_ch", 64'(upd_ch), 64'(exp_ch));
    check("dist_mm", 64'(dist_mm), 64'(m_dist));
    check("valid", 64'(valid), 64'(m_valid));
    check("no_echo", 64'(no_echo), 64'(m_ne));
    check("over_range", 64'(over_range), 64'(m_over));
    if (kind != K_HOLD) begin
      tick();
      check("upd_pulse", 64'(upd), 64'd0);
    end
    exp_ch = (exp_ch + 1) % N_CH;
  endtask

  vec_t tbl[8];

  initial begin
    int n;
    int quiet;
    tbl[0] = '{200, 50,   K_PULSE, 10,  1'b1, 1'b0, 1'b0};
    tbl[1] = '{0,   0,    K_NONE,  0,   1'b0, 1'b1, 1'b0};
    tbl[2] = '{100, 2050, K_PULSE, 400, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{150, 0,    K_HOLD,  400, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{30,  7,    K_PULSE, 1,   1'b1, 1'b0, 1'b0};
    tbl[5] = '{60,  4,    K_PULSE, 0,   1'b1, 1'b0, 1'b0};
    tbl[6] = '{10,  1999, K_PULSE, 399, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{80,  2000, K_PULSE, 400, 1'b0, 1'b0, 1'b1};

    enable = 1'b1;
    repeat (3) tick();
    check("reset_dist", 64'(dist_mm), 64'd0);
    check("reset_ctl", 64'({trig, valid, no_echo, over_range, upd, upd_ch}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_slot(tbl[i].dly, tbl[i].h, tbl[i].kind, 1'b0, (i == 1),
               tbl[i].e_dist, tbl[i].e_valid, tbl[i].e_ne, tbl[i].e_over);

    // Enable dropped during the ch1 slot.
    run_slot(40, 100, K_PULSE, 1'b0, 1'b0, 20, 1'b1, 1'b0, 1'b0);
    run_slot(50, 333, K_PULSE, 1'b1, 1'b0, 66, 1'b1, 1'b0, 1'b0);
    quiet = 0;
    for (int i = 0; i < 2 * SLOT_CYC; i++) begin
      tick();
      if (trig != '0) quiet++;
    end
    check("no_trig_disabled", 64'(quiet), 64'd0);
    enable = 1'b1;

    for (int i = 0; i < 10; i++) begin
      int r, kind, dly, h, d;
      bit v, ne, o;
      r = int'($urandom_range(0, 5));
      kind = (r == 0) ? K_NONE : (r == 1) ? K_HOLD : K_PULSE;
      dly = int'($urandom_range(0, 300));
      h = int'($urandom_range(1, 2100));
      model(kind, h, prev_dist(exp_ch), d, v, ne, o);
      run_slot(dly, h, kind, 1'b0, (i % 2 == 1), d, v, ne, o);
    end

    // Asynchronous reset while measuring.
    n = 0;
    while (trig == '0 && n < 2 * SLOT_CYC) begin tick(); n++; end
    n = 0;
    while (trig != '0 && n < TRIG_CYC + 5) begin tick(); n++; end
    repeat (40) tick();
    echo[exp_ch] = 1'b1;
    repeat (30) tick();
    #2 reset = 1'b1;
    #1;
    check("async_reset_dist", 64'(dist_mm), 64'd0);
    check("async_reset_ctl", 64'({trig, valid, no_echo, over_range, upd, upd_ch}), 64'd0);
    echo = '0;
    repeat (3) tick();
    reset = 1'b0;
    m_dist = '0; m_valid = '0; m_ne = '0; m_over = '0;
    exp_ch = 0;
    run_slot(100, 123, K_PULSE, 1'b0, 1'b0, 24, 1'b1, 1'b0, 1'b0);

    check("trig_exclusive", 64'(overlap), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sonar_ranging_array.md
Name: sonar_ranging_array

Overview:
- Multi-channel HC-SR04 style ultrasonic ranging controller.
- Time-multiplexes N_CH sensors round-robin, one measurement slot per channel, so echoes from adjacent sensors do not cross-talk.
- Per channel it generates the trigger pulse, times the echo in millimetres, and flags no-echo and over-range faults.
- Feeds the position/matrix display logic with one registered distance per channel and an update strobe.

Parameters:
- N_CH, 4, number of sensor channels (1..8).
- DIST_W, 12, distance output width in mm.
- SLOT_CYC, 1250000, clock cycles per channel slot (25 ms at 50 MHz; 4 channels give a 100 ms scan).
- TRIG_CYC, 500, trigger high time in cycles (10 us).
- CYC_PER_MM, 295, echo-high cycles per 1 mm of range (calibration).
- MAX_MM, 4000, saturation distance in mm; must be < 2^DIST_W.
- RISE_TO_CYC, 100000, maximum cycles from trigger fall to echo rise before NO_ECHO (2 ms).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- enable, input, 1, scan enable; sampled at slot boundaries.
- echo, input, N_CH, raw echo lines (asynchronous).
- trig, output, N_CH, trigger lines, registered.
- dist_mm, output, N_CH*DIST_W, channel k at bits [k*DIST_W +: DIST_W].
- valid, output, N_CH, 1 = last measurement of channel k good.
- no_echo, output, N_CH, 1 = last slot of channel k saw no echo rise.
- over_range, output, N_CH, 1 = echo still high at slot end, or count saturated.
- upd, output, 1, one-cycle pulse when any channel's result registers are written.
- upd_ch, output, 3, channel index written on the upd cycle.

Behaviour:
- Reset (asynchronous, reset=1) clears all outputs to 0, and sets channel pointer=0, slot counter=0, state=IDLE.
- Echo lines pass through a 2-FF synchroniser per channel. Both edges are delayed by 2 cycles, so pulse width is preserved.
- Slot counter sc runs 0..SLOT_CYC-1 and wraps. At wrap, ch advances to (ch+1) mod N_CH.
- The slot counter runs only while state != IDLE.
- FSM states and transitions:
  - IDLE: enter TRIG when enable=1; sc=0.
  - TRIG: trig[ch]=1 for exactly TRIG_CYC cycles, then go to WAIT_RISE. All other trig bits stay 0.
  - WAIT_RISE: a wait counter counts cycles.
    - Synced echo[ch]=1 → MEASURE; clear prescaler and mm counter.
    - Wait counter reaches RISE_TO_CYC → write no_echo[ch]=1, valid[ch]=0, over_range[ch]=0; dist_mm[ch] keeps its previous value; pulse upd; go to DONE.
  - MEASURE: the prescaler counts echo-high cycles.
    - When the prescaler reaches CYC_PER_MM-1 it resets, and mm increments, saturating at MAX_MM.
    - On synced echo fall: dist_mm[ch]=mm, valid[ch]=(mm<MAX_MM), over_range[ch]=(mm==MAX_MM), no_echo[ch]=0; pulse upd; go to DONE.
  - DONE: hold until the slot end.
  - Slot end, sc==SLOT_CYC-1, any state: if in MEASURE, write dist_mm[ch]=MAX_MM, over_range=1, valid=0, and pulse upd. Then go to TRIG for the next channel if enable=1, else IDLE.
- Distance arithmetic: dist = min(floor(H / CYC_PER_MM), MAX_MM), where H = synced high cycles.
- Echo rising during TRIG is ignored. WAIT_RISE requires a rising level only after TRIG ends.
- Echo on non-selected channels is ignored.
- enable dropped mid-slot: the current slot completes normally.
- Result registers change only on the upd cycle. upd_ch equals the ch just measured.
- Latency: upd is asserted 3 cycles after the raw echo fall (2 synchroniser cycles + 1 register cycle).
- N_CH=1: ch is always 0 and slots repeat back-to-back.

Decomposition:
- Shared package sonar_pkg holds:
  - FSM state encoding (IDLE, TRIG, WAIT_RISE, MEASURE, DONE);
  - default timing constants (CLK_HZ=50_000_000, CYC_PER_MM=295);
  - a function for the channel-index width, clog2 of N_CH.
- One sub-module: echo_sync, a parametrised N-bit 2-FF synchroniser. The FSM, counters and result banks stay in the top.

Test Plan:
- After reset with enable=1, N_CH=4: trig[0] is high for exactly 500 cycles starting at the first sc; trig[1] rises 1250000 cycles later. No two trig bits are ever high together.
- Ch0 echo high for 2950 cycles, starting 20000 cycles after trig fall → upd with upd_ch=0, dist_mm[0]=10, valid[0]=1, upd 3 cycles after the echo fall.
- Ch1 echo never rises → after 100000 cycles no_echo[1]=1, valid[1]=0, and dist_mm[1] keeps its prior value of 0.
- Ch2 echo high for 295*4100 cycles → dist_mm[2]=4000, over_range[2]=1, valid[2]=0. Ch3 echo held high past slot end → upd at sc=SLOT_CYC-1 with over_range[3]=1.
- enable dropped mid-slot of ch1 → the ch1 result is still written; no further trig pulses occur; re-enable → next trig is on ch2.
- Assert reset while in MEASURE → all outputs 0 immediately (asynchronous). On release the scan restarts at ch0 with a fresh TRIG.
